// File: rtl/esfa_pkg.sv
// Shared types for the associative array controller: opcodes, FSM states and the
// reduction-tree node with its lowest-handle-wins combine function.
package esfa_pkg;

  // Tree nodes are sized for the widest supported configuration; the top narrows them.
  localparam int unsigned NODE_HANDLE_W = 16;
  localparam int unsigned NODE_VALUE_W  = 32;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_FIND   = 3'd2;
  localparam logic [2:0] OP_INSERT = 3'd3;
  localparam logic [2:0] OP_DELETE = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StExec,
    StResp
  } esfa_state_e;

  typedef struct packed {
    logic                     hit;
    logic                     free;
    logic [NODE_HANDLE_W-1:0] hit_handle;
    logic [NODE_HANDLE_W-1:0] free_handle;
    logic [NODE_VALUE_W-1:0]  value;
  } esfa_node_t;

  function automatic esfa_node_t esfa_combine(input esfa_node_t l, input esfa_node_t r);
    esfa_node_t n;
    n.hit         = l.hit | r.hit;
    n.free        = l.free | r.free;
    n.hit_handle  = l.hit ? l.hit_handle : r.hit_handle;
    n.value       = l.hit ? l.value : r.value;
    n.free_handle = l.free ? l.free_handle : r.free_handle;
    return n;
  endfunction

endpackage

// File: rtl/esfa_array_ctrl_if.sv
// Command/response handshake bundle between the host and esfa_array_ctrl.
interface esfa_array_ctrl_if #(
  parameter int unsigned NUM_CELLS = 8,
  parameter int unsigned DATA_W    = 8
);
  localparam int unsigned HANDLE_W = $clog2(NUM_CELLS);
  localparam int unsigned OCC_W    = $clog2(NUM_CELLS) + 1;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [HANDLE_W-1:0] cmd_handle;
  logic [DATA_W-1:0]   cmd_index;
  logic [DATA_W-1:0]   cmd_value;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_ok;
  logic [DATA_W-1:0]   rsp_value;
  logic                busy;
  logic [OCC_W-1:0]    occupancy;

  modport master (
    output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_value, busy, occupancy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, rsp_ready,
    output cmd_ready, rsp_valid, rsp_ok, rsp_value, busy, occupancy
  );

endinterface

// File: rtl/esfa_cell.sv
// One associative storage cell: valid/index/value registers and the match/free
// signals that feed the reduction tree.
module esfa_cell #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              clr_en,
  input  logic [DATA_W-1:0] wr_index,
  input  logic [DATA_W-1:0] wr_value,
  input  logic [DATA_W-1:0] key,
  output logic              match,
  output logic              free,
  output logic [DATA_W-1:0] value
);

  logic              valid_q;
  logic [DATA_W-1:0] index_q;
  logic [DATA_W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      index_q <= '0;
      value_q <= '0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
      index_q <= wr_index;
      value_q <= wr_value;
    end else if (clr_en) begin
      valid_q <= 1'b0;
    end
  end

  assign match = valid_q && (index_q == key);
  assign free  = !valid_q;
  assign value = value_q;

endmodule

// File: rtl/esfa_array_ctrl.sv
// Associative array controller: accepts one command, searches all cells through a
// lowest-handle-wins tree, executes and returns one response. ESFA_PIPE_TREE_EN
// registers every tree level (search latency log2(NUM_CELLS) extra cycles).
module esfa_array_ctrl
  import esfa_pkg::*;
#(
  parameter int unsigned NUM_CELLS = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned HANDLE_W  = $clog2(NUM_CELLS)
) (
  input logic              clk,
  input logic              reset,
  esfa_array_ctrl_if.slave bus
);

  localparam int unsigned OCC_W     = HANDLE_W + 1;
  localparam int unsigned NUM_NODES = 2 * NUM_CELLS - 1;
`ifdef ESFA_PIPE_TREE_EN
  localparam int unsigned TREE_LAT  = HANDLE_W;
`else
  localparam int unsigned TREE_LAT  = 0;
`endif

  esfa_state_e         state_q, state_d;
  logic [7:0]          lat_cnt_q, lat_cnt_d;
  logic [2:0]          op_q;
  logic [HANDLE_W-1:0] handle_q;
  logic [DATA_W-1:0]   index_q;
  logic [DATA_W-1:0]   value_q;
  logic                rsp_ok_q, rsp_ok_d;
  logic [DATA_W-1:0]   rsp_value_q, rsp_value_d;
  logic [OCC_W-1:0]    occ_q, occ_d;

  logic [NUM_CELLS-1:0] cell_match, cell_free, cell_wr, cell_clr;
  logic [DATA_W-1:0]    cell_value [NUM_CELLS];

  // Heap layout: node n has children 2n+1 / 2n+2; leaves start at NUM_CELLS-1.
  esfa_node_t          nodes [NUM_NODES];
  esfa_node_t          root;
  logic [HANDLE_W-1:0] hit_handle, free_handle;
  logic                unused_root;

  for (genvar c = 0; c < NUM_CELLS; c++) begin : g_cell
    esfa_cell #(
      .DATA_W(DATA_W)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (cell_wr[c]),
      .clr_en  (cell_clr[c]),
      .wr_index(index_q),
      .wr_value(value_q),
      .key     (index_q),
      .match   (cell_match[c]),
      .free    (cell_free[c]),
      .value   (cell_value[c])
    );

    assign nodes[NUM_CELLS-1+c] = '{
      hit:         cell_match[c],
      free:        cell_free[c],
      hit_handle:  NODE_HANDLE_W'(c),
      free_handle: NODE_HANDLE_W'(c),
      value:       NODE_VALUE_W'(cell_value[c])
    };
  end

  for (genvar n = 0; n < NUM_CELLS - 1; n++) begin : g_node
`ifdef ESFA_PIPE_TREE_EN
    esfa_node_t node_q;
    always_ff @(posedge clk) begin
      if (!reset) node_q <= '0;
      else        node_q <= esfa_combine(nodes[2*n+1], nodes[2*n+2]);
    end
    assign nodes[n] = node_q;
`else
    assign nodes[n] = esfa_combine(nodes[2*n+1], nodes[2*n+2]);
`endif
  end

  assign root        = nodes[0];
  assign hit_handle  = root.hit_handle[HANDLE_W-1:0];
  assign free_handle = root.free_handle[HANDLE_W-1:0];
  assign unused_root = ^root;

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    rsp_ok_d    = rsp_ok_q;
    rsp_value_d = rsp_value_q;
    occ_d       = occ_q;
    cell_wr     = '0;
    cell_clr    = '0;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          state_d   = StSearch;
          lat_cnt_d = '0;
        end
      end
      StSearch: begin
        if (lat_cnt_q == 8'(TREE_LAT)) state_d = StExec;
        else                           lat_cnt_d = lat_cnt_q + 8'd1;
      end
      StExec: begin
        state_d     = StResp;
        rsp_ok_d    = 1'b0;
        rsp_value_d = '0;
        case (op_q)
          OP_NOP: rsp_ok_d = 1'b1;
          OP_READ: begin
            rsp_ok_d    = !cell_free[handle_q];
            rsp_value_d = cell_free[handle_q] ? '0 : cell_value[handle_q];
          end
          OP_FIND: begin
            rsp_ok_d    = root.hit;
            rsp_value_d = root.hit ? root.value[DATA_W-1:0] : '0;
          end
          OP_INSERT: begin
            if (root.hit) begin
              cell_wr[hit_handle] = 1'b1;
              rsp_ok_d            = 1'b1;
              rsp_value_d         = DATA_W'(hit_handle);
            end else if (root.free) begin
              cell_wr[free_handle] = 1'b1;
              rsp_ok_d             = 1'b1;
              rsp_value_d          = DATA_W'(free_handle);
              occ_d                = occ_q + OCC_W'(1);
            end
          end
          OP_DELETE: begin
            if (root.hit) begin
              cell_clr[hit_handle] = 1'b1;
              rsp_ok_d             = 1'b1;
              rsp_value_d          = DATA_W'(hit_handle);
              occ_d                = occ_q - OCC_W'(1);
            end
          end
          OP_COUNT: begin
            rsp_ok_d    = 1'b1;
            rsp_value_d = DATA_W'(occ_q);
          end
          default: ;
        endcase
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      op_q        <= OP_NOP;
      handle_q    <= '0;
      index_q     <= '0;
      value_q     <= '0;
      rsp_ok_q    <= 1'b0;
      rsp_value_q <= '0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_value_q <= rsp_value_d;
      occ_q       <= occ_d;
      if (state_q == StIdle && bus.cmd_valid) begin
        op_q     <= bus.cmd_op;
        handle_q <= bus.cmd_handle;
        index_q  <= bus.cmd_index;
        value_q  <= bus.cmd_value;
      end
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_ok    = rsp_ok_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_esfa_array_ctrl.sv
// Directed bench for esfa_array_ctrl with a reference model feeding a response scoreboard.
module tb_esfa_array_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 8;
`ifdef ESFA_PIPE_TREE_EN
  localparam int EXP_LAT = 6;
`else
  localparam int EXP_LAT = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  esfa_array_ctrl_if #(.NUM_CELLS(N), .DATA_W(DW)) bus ();

  esfa_array_ctrl #(
    .NUM_CELLS(N),
    .DATA_W   (DW),
    .HANDLE_W (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];

  logic       m_valid [N];
  logic [7:0] m_idx   [N];
  logic [7:0] m_val   [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_idx[i]   = '0;
      m_val[i]   = '0;
    end
  endtask

  function automatic int model_count();
    int cnt = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) cnt++;
    return cnt;
  endfunction

  // Reference behaviour: linear scan, lowest handle first.
  task automatic model(input logic [2:0] op, input int handle, input logic [7:0] index,
                       input logic [7:0] value, output logic ok, output logic [7:0] val);
    int  h = -1;
    int  f = -1;
    ok  = 1'b0;
    val = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_valid[i] && m_idx[i] == index) h = i;
      if (!m_valid[i]) f = i;
    end
    case (op)
      3'd0: ok = 1'b1;
      3'd1: if (m_valid[handle]) begin ok = 1'b1; val = m_val[handle]; end
      3'd2: if (h >= 0) begin ok = 1'b1; val = m_val[h]; end
      3'd3: begin
        if (h >= 0) begin
          m_val[h] = value; ok = 1'b1; val = 8'(h);
        end else if (f >= 0) begin
          m_valid[f] = 1'b1; m_idx[f] = index; m_val[f] = value; ok = 1'b1; val = 8'(f);
        end
      end
      3'd4: if (h >= 0) begin m_valid[h] = 1'b0; ok = 1'b1; val = 8'(h); end
      3'd5: begin ok = 1'b1; val = 8'(model_count()); end
      default: ;
    endcase
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [2:0] handle,
                           input logic [7:0] index, input logic [7:0] value);
    logic       ok;
    logic [7:0] v;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_handle = handle;
    bus.cmd_index  = index;
    bus.cmd_value  = value;
    model(op, int'(handle), index, value, ok, v);
    exp_q.push_back({ok, v});
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [2:0] handle,
                        input logic [7:0] index, input logic [7:0] value);
    logic [8:0] e;
    int         k;
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.cmd_ready), 32'd1);
    drive_cmd(op, handle, index, value);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 1;
    while (!bus.rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".lat"}, 32'(k), 32'(EXP_LAT));
    e = exp_q.pop_front();
    check({tag, ".ok"}, 32'(bus.rsp_ok), 32'(e[8]));
    check({tag, ".value"}, 32'(bus.rsp_value), 32'(e[7:0]));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] e;
    int         k;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_handle = '0;
    bus.cmd_index  = '0;
    bus.cmd_value  = '0;
    bus.rsp_ready  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_ok", 32'(bus.rsp_ok), 32'd0);
    check("rst.rsp_value", 32'(bus.rsp_value), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.occ", 32'(bus.occupancy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);

    do_cmd("count0", 3'd5, 3'd0, 8'h00, 8'h00);
    do_cmd("ins11", 3'd3, 3'd0, 8'h11, 8'hA5);
    do_cmd("find11", 3'd2, 3'd0, 8'h11, 8'h00);
    do_cmd("read0", 3'd1, 3'd0, 8'h00, 8'h00);
    do_cmd("read1_empty", 3'd1, 3'd1, 8'h00, 8'h00);

    // Fill remaining cells, then overflow
    for (int i = 1; i < 8; i++) do_cmd("fill", 3'd3, 3'd0, 8'(8'h20 + i), 8'(8'h80 + i));
    do_cmd("ins_full", 3'd3, 3'd0, 8'h40, 8'h99);
    check("full.occ", 32'(bus.occupancy), 32'd8);

    do_cmd("del23", 3'd4, 3'd0, 8'h23, 8'h00);
    check("del.occ", 32'(bus.occupancy), 32'd7);
    do_cmd("del_miss", 3'd4, 3'd0, 8'h23, 8'h00);
    do_cmd("ins55", 3'd3, 3'd0, 8'h55, 8'h12);
    do_cmd("upsert55", 3'd3, 3'd0, 8'h55, 8'h3C);
    check("upsert.occ", 32'(bus.occupancy), 32'd8);
    do_cmd("find55", 3'd2, 3'd0, 8'h55, 8'h00);
    do_cmd("find_miss", 3'd2, 3'd0, 8'h23, 8'h00);
    do_cmd("read6", 3'd1, 3'd6, 8'h00, 8'h00);
    do_cmd("op6", 3'd6, 3'd0, 8'h11, 8'h00);
    do_cmd("op7", 3'd7, 3'd0, 8'h11, 8'h00);
    do_cmd("nop", 3'd0, 3'd0, 8'h00, 8'h00);
    do_cmd("count8", 3'd5, 3'd0, 8'h00, 8'h00);

    // Stalled response: outputs hold, further commands ignored
    @(negedge clk);
    drive_cmd(3'd2, 3'd0, 8'h27, 8'h00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 1;
    while (!bus.rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stall.lat", 32'(k), 32'(EXP_LAT));
    e = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      check("stall.rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall.rsp_ok", 32'(bus.rsp_ok), 32'(e[8]));
      check("stall.rsp_value", 32'(bus.rsp_value), 32'(e[7:0]));
      check("stall.cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("stall.busy", 32'(bus.busy), 32'd1);
      bus.cmd_valid = (c >= 3 && c <= 5);
      bus.cmd_op    = 3'd3;
      bus.cmd_index = 8'hEE;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("stall.idle_busy", 32'(bus.busy), 32'd0);
    check("stall.idle_rsp", 32'(bus.rsp_valid), 32'd0);
    check("stall.occ", 32'(bus.occupancy), 32'd8);
    do_cmd("find_ee_absent", 3'd2, 3'd0, 8'hEE, 8'h00);

    // Reset during SEARCH of an INSERT aborts it
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    bus.cmd_index = 8'h77;
    bus.cmd_value = 8'h42;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("abort.in_search", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort.occ", 32'(bus.occupancy), 32'd0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("abort.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort.rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    do_cmd("abort.find77", 3'd2, 3'd0, 8'h77, 8'h00);
    do_cmd("abort.read0", 3'd1, 3'd0, 8'h00, 8'h00);
    do_cmd("abort.count", 3'd5, 3'd0, 8'h00, 8'h00);
    do_cmd("abort.ins", 3'd3, 3'd0, 8'h01, 8'h02);

    check("sb.empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
